sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Central scheduler inside the SDRAM controller (sdram_main_ctrl level). Holds the bus in INIT until the init sequencer finishes, then grants the single SDRAM command/address bus to one of three engines: auto-refresh, write-burst, read-burst.
- Owns the periodic refresh timer. Raises ref_pending so the write and read engines end their current burst early.
- Muxes the granted engine's cmd/addr/ba onto the SDRAM pins and detects engines that never signal completion.

Parameters:
- REF_PERIOD, 1500: sclk cycles between refresh requests. The default gives margin under 15.6 us at 100 MHz.
- TIMEOUT, 1024: maximum cycles in AREF, WRITE or READ before a forced return to ARBIT.
- NOP_CMD, 4'b0111: {cs_n, ras_n, cas_n, we_n} driven while idle or arbitrating.

Ports:
- sclk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high reset
- ini_end  in  1  init sequence complete (level)
- init_cmd, init_addr  in  4, 12  init sequencer bus
- wr_req, rd_req  in  1  level requests from the write and read engines
- ref_end, wr_end, rd_end  in  1  one-cycle completion pulses from the engines
- ref_cmd, ref_addr  in  4, 12  refresh engine bus
- wr_cmd, wr_addr, wr_ba  in  4, 12, 2  write engine bus
- rd_cmd, rd_addr, rd_ba  in  4, 12, 2  read engine bus
- ref_en, wr_en, rd_en  out  1  one-cycle grant pulses
- ref_pending  out  1  refresh owed; write/read engines must finish the current burst
- sdram_cmd, sdram_addr, sdram_ba  out  4, 12, 2  muxed SDRAM bus
- state  out  3  current state (INIT=0, ARBIT=1, AREF=2, WRITE=3, READ=4)
- err  out  1  sticky: an engine timed out

Behaviour:
Reset values (rst high on a sclk edge):
- state=INIT; ref_en=wr_en=rd_en=0; ref_pending=0; err=0.
- Refresh counter and watchdog counter = 0.
- rst overrides everything, including mid-burst. If ini_end is still high after reset, ARBIT is reached on the next edge.

State transitions:
- INIT: sdram bus = init_cmd/init_addr, ba=0. ini_end=1 -> ARBIT on the next edge.
- ARBIT: bus = NOP_CMD, addr 0, ba 0. Fixed priority ref_pending > wr_req > rd_req.
  - Request sampled at edge N -> state becomes AREF/WRITE/READ at N+1.
  - The matching *_en is high for exactly cycle N+1.
  - No request -> stay in ARBIT.
- AREF: bus = ref_*, ba=0. ref_end -> ARBIT.
- WRITE: bus = wr_*. wr_end -> ARBIT.
- READ: bus = rd_*. rd_end -> ARBIT.
- End pulses that do not match the current state are ignored.
- ARBIT always lasts at least one cycle (one NOP) between consecutive grants: end at N, ARBIT at N+1, next service state at N+2.

Refresh timer:
- Runs only when state != INIT; counts 0..REF_PERIOD-1, then wraps.
- At the wrap cycle ref_pending <= 1.
- ref_pending clears in the cycle ref_en is asserted.
- Wrap and ref_en in the same cycle -> ref_pending stays 1 (the new request wins).
- Wrap while ref_pending is already 1 -> stays 1; refreshes are not queued.

Watchdog:
- Clears on entry to AREF, WRITE or READ; increments every cycle in those states.
- Reaching TIMEOUT-1 without the matching end pulse -> ARBIT on the next edge and err <= 1.
- err clears only on rst.

Output timing:
- Bus mux is combinational from the registered state (zero latency).
- *_en, ref_pending and err are registered.

Test Plan:
- Reset then ini_end=1 at cycle 10 -> state INIT until cycle 10, ARBIT at 11; sdram_cmd=init_cmd before, 4'b0111 after.
- wr_req and rd_req both held in ARBIT -> WRITE granted, wr_en one cycle. wr_end -> one ARBIT cycle with NOP, then READ, rd_en one cycle.
- REF_PERIOD=20, wr_req held constantly, wr_end every 8 cycles in WRITE -> ref_pending rises on counter wrap; next ARBIT grants AREF, not WRITE; ref_pending falls with ref_en.
- Counter wraps in the same cycle ref_en fires -> ref_pending remains 1; a second AREF is granted after the next ARBIT.
- TIMEOUT=16, grant WRITE, never pulse wr_end -> state returns to ARBIT after 16 WRITE cycles, err=1, and err stays 1 through later normal grants.
- rst asserted mid-READ -> state=INIT, all *_en and ref_pending 0 on the next edge; ini_end held high -> ARBIT one cycle after rst drops.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Bus between the SDRAM arbiter and its clients: init sequencer, refresh/write/read
// engines, and the muxed SDRAM command/address pins.
interface sdram_arbiter_if;
  logic        ini_end;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic        wr_req;
  logic        rd_req;
  logic        ref_end;
  logic        wr_end;
  logic        rd_end;
  logic [3:0]  ref_cmd;
  logic [11:0] ref_addr;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_ba;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_ba;
  logic        ref_en;
  logic        wr_en;
  logic        rd_en;
  logic        ref_pending;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic [2:0]  state;
  logic        err;

  // Requests and *_end pulses are levels/pulses sampled on the sclk edge; a grant is
  // the one-cycle *_en pulse, and the engine owns the bus until its *_end pulse.
  modport slave (
    input  ini_end, init_cmd, init_addr, wr_req, rd_req, ref_end, wr_end, rd_end,
    input  ref_cmd, ref_addr, wr_cmd, wr_addr, wr_ba, rd_cmd, rd_addr, rd_ba,
    output ref_en, wr_en, rd_en, ref_pending, sdram_cmd, sdram_addr, sdram_ba, state, err
  );

  modport master (
    output ini_end, init_cmd, init_addr, wr_req, rd_req, ref_end, wr_end, rd_end,
    output ref_cmd, ref_addr, wr_cmd, wr_addr, wr_ba, rd_cmd, rd_addr, rd_ba,
    input  ref_en, wr_en, rd_en, ref_pending, sdram_cmd, sdram_addr, sdram_ba, state, err
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Central SDRAM scheduler: waits for init, then grants the command bus to refresh,
// write or read engines with a periodic refresh timer and a per-grant watchdog.
module sdram_arbiter #(
  parameter int          REF_PERIOD = 1500,
  parameter int          TIMEOUT    = 1024,
  parameter logic [3:0]  NOP_CMD    = 4'b0111
) (
  input  logic          sclk,
  input  logic          rst,
  sdram_arbiter_if.slave bus
);

  localparam int RCW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t           state_q;
  logic [RCW-1:0]   ref_cnt;
  logic [WDW-1:0]   wd_cnt;
  logic             ref_en_q;
  logic             wr_en_q;
  logic             rd_en_q;
  logic             ref_pending_q;
  logic             err_q;

  logic ref_wrap;
  logic ref_grant;
  logic wd_expired;
  logic svc_end;

  assign ref_wrap   = (state_q != S_INIT) && (ref_cnt == RCW'(REF_PERIOD - 1));
  assign ref_grant  = (state_q == S_ARBIT) && ref_pending_q;
  assign wd_expired = (wd_cnt == WDW'(TIMEOUT - 1));
  // Only the end pulse of the engine that currently owns the bus counts.
  assign svc_end    = ((state_q == S_AREF)  && bus.ref_end) ||
                      ((state_q == S_WRITE) && bus.wr_end)  ||
                      ((state_q == S_READ)  && bus.rd_end);

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q       <= S_INIT;
      ref_cnt       <= '0;
      wd_cnt        <= '0;
      ref_en_q      <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      ref_pending_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      ref_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      wd_cnt   <= wd_cnt + 1'b1;

      if (state_q != S_INIT) ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;

      // A wrap coinciding with the refresh grant re-arms the request immediately.
      if (ref_wrap)       ref_pending_q <= 1'b1;
      else if (ref_grant) ref_pending_q <= 1'b0;

      case (state_q)
        S_INIT: begin
          wd_cnt <= '0;
          if (bus.ini_end) state_q <= S_ARBIT;
        end
        S_ARBIT: begin
          wd_cnt <= '0;
          if (ref_pending_q) begin
            state_q  <= S_AREF;
            ref_en_q <= 1'b1;
          end else if (bus.wr_req) begin
            state_q <= S_WRITE;
            wr_en_q <= 1'b1;
          end else if (bus.rd_req) begin
            state_q <= S_READ;
            rd_en_q <= 1'b1;
          end
        end
        S_AREF, S_WRITE, S_READ: begin
          if (svc_end) begin
            state_q <= S_ARBIT;
          end else if (wd_expired) begin
            state_q <= S_ARBIT;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  always_comb begin
    bus.sdram_cmd  = NOP_CMD;
    bus.sdram_addr = '0;
    bus.sdram_ba   = '0;
    case (state_q)
      S_INIT: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_addr = bus.init_addr;
      end
      S_AREF: begin
        bus.sdram_cmd  = bus.ref_cmd;
        bus.sdram_addr = bus.ref_addr;
      end
      S_WRITE: begin
        bus.sdram_cmd  = bus.wr_cmd;
        bus.sdram_addr = bus.wr_addr;
        bus.sdram_ba   = bus.wr_ba;
      end
      S_READ: begin
        bus.sdram_cmd  = bus.rd_cmd;
        bus.sdram_addr = bus.rd_addr;
        bus.sdram_ba   = bus.rd_ba;
      end
      default: begin
        bus.sdram_cmd  = NOP_CMD;
        bus.sdram_addr = '0;
        bus.sdram_ba   = '0;
      end
    endcase
  end

  assign bus.state       = state_q;
  assign bus.ref_en      = ref_en_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.ref_pending = ref_pending_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed vector bench for sdram_arbiter with a short refresh period and watchdog,
// so refresh preemption, wrap/grant collision and timeout all occur within ~100 cycles.
module tb_sdram_arbiter;

  localparam logic [2:0] I = 3'd0;
  localparam logic [2:0] A = 3'd1;
  localparam logic [2:0] F = 3'd2;
  localparam logic [2:0] W = 3'd3;
  localparam logic [2:0] R = 3'd4;

  typedef struct {
    logic       rst, ini, wr, rd, rfe, wre, rde;
    logic [2:0] st;
    logic       ren, wen, rden, pend, err;
  } vec_t;

  logic sclk;
  logic rst;
  int   total;
  int   bad;
  vec_t vecs[$];

  sdram_arbiter_if bus();

  sdram_arbiter #(.REF_PERIOD(12), .TIMEOUT(16)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input int n, input logic r, input logic ini, input logic wr, input logic rd,
                     input logic rfe, input logic wre, input logic rde, input logic [2:0] st,
                     input logic ren, input logic wen, input logic rden, input logic pend,
                     input logic err);
    vec_t v;
    v.rst = r;  v.ini = ini; v.wr = wr; v.rd = rd; v.rfe = rfe; v.wre = wre; v.rde = rde;
    v.st = st;  v.ren = ren; v.wen = wen; v.rden = rden; v.pend = pend; v.err = err;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  function automatic void exp_bus(input logic [2:0] st, output logic [3:0] c,
                                  output logic [11:0] a, output logic [1:0] b);
    case (st)
      I:       begin c = 4'h1; a = 12'h111; b = 2'd0; end
      F:       begin c = 4'h2; a = 12'h222; b = 2'd0; end
      W:       begin c = 4'h3; a = 12'h333; b = 2'd1; end
      R:       begin c = 4'h4; a = 12'h444; b = 2'd2; end
      default: begin c = 4'b0111; a = 12'h000; b = 2'd0; end
    endcase
  endfunction

  task automatic check_all(input int idx, input logic [2:0] st, input logic ren, input logic wen,
                           input logic rden, input logic pend, input logic err);
    logic [3:0]  c;
    logic [11:0] a;
    logic [1:0]  b;
    exp_bus(st, c, a, b);
    check("state",       idx, 12'(bus.state),       12'(st));
    check("ref_en",      idx, 12'(bus.ref_en),      12'(ren));
    check("wr_en",       idx, 12'(bus.wr_en),       12'(wen));
    check("rd_en",       idx, 12'(bus.rd_en),       12'(rden));
    check("ref_pending", idx, 12'(bus.ref_pending), 12'(pend));
    check("err",         idx, 12'(bus.err),         12'(err));
    check("sdram_cmd",   idx, 12'(bus.sdram_cmd),   12'(c));
    check("sdram_addr",  idx, bus.sdram_addr,       a);
    check("sdram_ba",    idx, 12'(bus.sdram_ba),    12'(b));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.ini_end = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    bus.ref_end = 1'b0; bus.wr_end = 1'b0; bus.rd_end = 1'b0;
    bus.init_cmd = 4'h1; bus.init_addr = 12'h111;
    bus.ref_cmd  = 4'h2; bus.ref_addr  = 12'h222;
    bus.wr_cmd   = 4'h3; bus.wr_addr   = 12'h333; bus.wr_ba = 2'd1;
    bus.rd_cmd   = 4'h4; bus.rd_addr   = 12'h444; bus.rd_ba = 2'd2;

    // Reset, init wait, write/read priority, mismatched end pulses, idle ARBIT.
    add(2, 1,0,0,0,0,0,0, I,0,0,0,0,0);
    add(9, 0,0,0,0,0,0,0, I,0,0,0,0,0);
    add(1, 0,1,0,0,0,0,0, A,0,0,0,0,0);
    add(1, 0,1,1,1,0,0,0, W,0,1,0,0,0);
    add(1, 0,1,1,1,0,0,0, W,0,0,0,0,0);
    add(1, 0,1,0,1,0,1,0, A,0,0,0,0,0);
    add(1, 0,1,0,1,0,0,0, R,0,0,1,0,0);
    add(1, 0,1,0,1,1,1,0, R,0,0,0,0,0);
    add(1, 0,1,0,0,0,0,1, A,0,0,0,0,0);
    add(2, 0,1,0,0,0,0,0, A,0,0,0,0,0);
    add(1, 0,1,0,1,0,0,0, R,0,0,1,0,0);
    add(1, 0,1,0,0,0,0,1, A,0,0,0,0,0);
    // Re-reset (second edge coincides with a timer wrap), then refresh preempts writes.
    add(2, 1,1,1,0,0,0,0, I,0,0,0,0,0);
    add(1, 0,1,1,0,0,0,0, A,0,0,0,0,0);
    add(1, 0,1,1,0,0,0,0, W,0,1,0,0,0);
    add(7, 0,1,1,0,0,0,0, W,0,0,0,0,0);
    add(1, 0,1,1,0,0,1,0, A,0,0,0,0,0);
    add(1, 0,1,1,0,0,0,0, W,0,1,0,0,0);
    add(1, 0,1,1,0,0,0,0, W,0,0,0,0,0);
    add(6, 0,1,1,0,0,0,0, W,0,0,0,1,0);
    add(1, 0,1,1,0,0,1,0, A,0,0,0,1,0);
    add(1, 0,1,1,0,0,0,0, F,1,0,0,0,0);
    add(1, 0,1,1,0,0,0,0, F,0,0,0,0,0);
    add(1, 0,1,1,0,1,0,0, A,0,0,0,0,0);
    add(1, 0,1,1,0,0,0,0, W,0,1,0,0,0);
    add(1, 0,1,1,0,0,0,0, W,0,0,0,0,0);
    add(11,0,1,1,0,0,0,0, W,0,0,0,1,0);
    add(1, 0,1,1,0,0,1,0, A,0,0,0,1,0);
    // Wrap on the refresh grant edge: pending stays, a second AREF follows.
    add(1, 0,1,1,0,0,0,0, F,1,0,0,1,0);
    add(1, 0,1,1,0,1,0,0, A,0,0,0,1,0);
    add(1, 0,1,1,0,0,0,0, F,1,0,0,0,0);
    add(1, 0,1,1,0,1,0,0, A,0,0,0,0,0);
    // Write with no end pulse: 16 WRITE cycles then forced ARBIT and sticky err.
    add(1, 0,1,1,0,0,0,0, W,0,1,0,0,0);
    add(7, 0,1,1,0,0,0,0, W,0,0,0,0,0);
    add(8, 0,1,1,0,0,0,0, W,0,0,0,1,0);
    add(1, 0,1,1,0,0,0,0, A,0,0,0,1,1);
    add(1, 0,1,1,0,0,0,0, F,1,0,0,0,1);
    add(1, 0,1,1,0,1,0,0, A,0,0,0,0,1);
    add(1, 0,1,1,0,0,0,0, W,0,1,0,0,1);
    add(1, 0,1,0,0,0,1,0, A,0,0,0,1,1);
    add(1, 0,1,0,0,0,0,0, F,1,0,0,0,1);
    add(1, 0,1,0,0,1,0,0, A,0,0,0,0,1);
    add(1, 0,1,0,1,0,0,0, R,0,0,1,0,1);
    add(8, 0,1,0,1,0,0,0, R,0,0,0,0,1);
    add(1, 0,1,0,1,0,0,0, R,0,0,0,1,1);
    // Reset mid-READ with refresh pending and err set; ini_end held high.
    add(1, 1,1,0,1,0,0,0, I,0,0,0,0,0);
    add(1, 0,1,0,1,0,0,0, A,0,0,0,0,0);
    add(1, 0,1,0,1,0,0,0, R,0,0,1,0,0);
    add(1, 0,1,0,0,0,0,1, A,0,0,0,0,0);

    foreach (vecs[i]) begin
      rst         = vecs[i].rst;
      bus.ini_end = vecs[i].ini;
      bus.wr_req  = vecs[i].wr;
      bus.rd_req  = vecs[i].rd;
      bus.ref_end = vecs[i].rfe;
      bus.wr_end  = vecs[i].wre;
      bus.rd_end  = vecs[i].rde;
      step();
      check_all(i, vecs[i].st, vecs[i].ren, vecs[i].wen, vecs[i].rden, vecs[i].pend, vecs[i].err);
    end

    // End pulse arriving on the last watchdog cycle wins: no err.
    bus.rd_end = 1'b0;
    bus.wr_req = 1'b1;
    step();
    check_all(1000, W, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.wr_req = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      check("wd_hold_state", 1001 + k, 12'(bus.state), 12'(W));
    end
    bus.wr_end = 1'b1;
    step();
    check_all(1100, A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.wr_end = 1'b0;
    step();
    check_all(1101, F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
